// File: rtl/video_pkg.sv
// Shared video constants, FSM state type and colour constants for the rasteriser
// and the framebuffer clear logic.
package video_pkg;

    localparam int unsigned H_RES = 640;
    localparam int unsigned V_RES = 480;
    localparam int unsigned XW    = 10;
    localparam int unsigned YW    = 9;
    localparam int unsigned AW    = 19;
    localparam int unsigned CW    = 6;

    // Error-term width: wide enough for dx + dy + dx with 10/9-bit endpoints.
    localparam int unsigned EW    = 12;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW,
        DONE
    } state_e;

    localparam logic [CW-1:0] BLACK = 6'h00;
    localparam logic [CW-1:0] WHITE = 6'h3F;

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational framebuffer address and visibility check for one (x, y) pixel.
// Row stride is 640 = 512 + 128, so the multiply reduces to two shifts and adds.
module fb_addr_calc
    import video_pkg::*;
(
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    output logic [AW-1:0] o_addr,
    output logic          o_in_range
);

    logic [AW-1:0] w_y_wide;
    logic [AW-1:0] w_x_wide;

    // Address = y*640 + x, and the on-screen flag used to suppress clipped writes.
    always_comb begin
        w_y_wide   = AW'(i_y);
        w_x_wide   = AW'(i_x);
        o_addr     = (w_y_wide << 9) + (w_y_wide << 7) + w_x_wide;
        o_in_range = (i_x < XW'(H_RES)) && (i_y < YW'(V_RES));
    end

endmodule

// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser: accepts one line command and emits one framebuffer
// write per DRAW cycle while draw_en is high. Off-screen pixels are stepped
// through but never written.
module line_raster_engine
    import video_pkg::*;
(
    input  logic          clk_50,
    input  logic          rst_n,
    input  logic          draw_en,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] color,
    output logic [AW-1:0] line_drawing_addr,
    output logic [CW-1:0] line_drawing_data,
    output logic          we_line,
    output logic          busy,
    output logic          done
);

    state_e r_state;
    state_e w_state_next;

    // Current pixel and latched end point / colour
    logic [XW-1:0] r_cur_x;
    logic [YW-1:0] r_cur_y;
    logic [XW-1:0] r_x1;
    logic [YW-1:0] r_y1;
    logic [CW-1:0] r_color;

    // Bresenham terms; r_dy is stored as -|y1-y0|
    logic signed [EW-1:0] r_dx;
    logic signed [EW-1:0] r_dy;
    logic signed [EW-1:0] r_err;
    logic                 r_sx_neg;
    logic                 r_sy_neg;

    // Registered write port and status
    logic [AW-1:0] r_addr;
    logic [CW-1:0] r_data;
    logic          r_we;
    logic          r_busy;
    logic          r_done;

    logic signed [EW-1:0] w_ddx;
    logic signed [EW-1:0] w_ddy;
    logic signed [EW-1:0] w_dx_abs;
    logic signed [EW-1:0] w_dy_abs;
    logic signed [EW:0]   w_e2;
    logic signed [EW:0]   w_dx_wide;
    logic signed [EW:0]   w_dy_wide;
    logic signed [EW-1:0] w_err_dx_term;
    logic signed [EW-1:0] w_err_dy_term;
    logic signed [EW-1:0] w_err_next;
    logic                 w_step_x;
    logic                 w_step_y;
    logic                 w_at_end;
    logic [AW-1:0]        w_addr;
    logic                 w_in_range;

    fb_addr_calc u_fb_addr_calc (
        .i_x        (r_cur_x),
        .i_y        (r_cur_y),
        .o_addr     (w_addr),
        .o_in_range (w_in_range)
    );

    // Setup deltas (r_cur holds the start point in SETUP) and the per-pixel step decision.
    always_comb begin
        w_ddx         = EW'(r_x1) - EW'(r_cur_x);
        w_ddy         = EW'(r_y1) - EW'(r_cur_y);
        w_dx_abs      = w_ddx[EW-1] ? -w_ddx : w_ddx;
        w_dy_abs      = w_ddy[EW-1] ? -w_ddy : w_ddy;
        w_e2          = {r_err, 1'b0};
        w_dx_wide     = {r_dx[EW-1], r_dx};
        w_dy_wide     = {r_dy[EW-1], r_dy};
        w_step_x      = (w_e2 >= w_dy_wide);
        w_step_y      = (w_e2 <= w_dx_wide);
        // Both updates use the pre-step error term.
        w_err_dy_term = w_step_x ? r_dy : '0;
        w_err_dx_term = w_step_y ? r_dx : '0;
        w_err_next    = r_err + w_err_dy_term + w_err_dx_term;
        w_at_end      = (r_cur_x == r_x1) && (r_cur_y == r_y1);
    end

    // FSM state register.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; DRAW only advances on a cycle where draw_en lets the pixel out.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (cmd_valid)            w_state_next = SETUP;
            SETUP:                             w_state_next = DRAW;
            DRAW:    if (draw_en && w_at_end)  w_state_next = DONE;
            DONE:                              w_state_next = IDLE;
            default:                           w_state_next = IDLE;
        endcase
    end

    // Datapath: command latch, Bresenham setup/step and the registered write port.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            r_cur_x  <= '0;
            r_cur_y  <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_color  <= BLACK;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_addr   <= '0;
            r_data   <= BLACK;
            r_we     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_cur_x <= x0;
                        r_cur_y <= y0;
                        r_x1    <= x1;
                        r_y1    <= y1;
                        r_color <= color;
                        r_busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    r_dx     <= w_dx_abs;
                    r_dy     <= -w_dy_abs;
                    r_err    <= w_dx_abs - w_dy_abs;
                    r_sx_neg <= w_ddx[EW-1];
                    r_sy_neg <= w_ddy[EW-1];
                end
                DRAW: begin
                    // draw_en low: everything holds and the write slot stays empty.
                    if (draw_en) begin
                        r_addr <= w_addr;
                        r_data <= r_color;
                        r_we   <= w_in_range;
                        if (!w_at_end) begin
                            r_err <= w_err_next;
                            if (w_step_x) begin
                                r_cur_x <= r_sx_neg ? r_cur_x - XW'(1) : r_cur_x + XW'(1);
                            end
                            if (w_step_y) begin
                                r_cur_y <= r_sy_neg ? r_cur_y - YW'(1) : r_cur_y + YW'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    // Output decode.
    always_comb begin
        cmd_ready         = (r_state == IDLE);
        line_drawing_addr = r_addr;
        line_drawing_data = r_data;
        we_line           = r_we;
        busy              = r_busy;
        done              = r_done;
    end

endmodule
